// File: rtl/pic_pkg.sv
// Shared types for the PIC sequencer: FSM states, redirect causes and the
// request priority encoder.
package pic_pkg;

   typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} seq_state_t;

   typedef enum logic [2:0] {
      RD_NONE, RD_JUMP, RD_CALL, RD_RET, RD_RETFIE, RD_REL, RD_SKIP, RD_IRQ
   } redirect_t;

   localparam int unsigned NOP_INSTR = 0;

   // Call outranks jump so a conflicting pair still leaves the stack consistent.
   function automatic redirect_t pick_cause(input logic call, input logic jump,
                                            input logic ret, input logic retfie,
                                            input logic rel, input logic skip,
                                            input logic irq_take);
      redirect_t c;
      if (call)          c = RD_CALL;
      else if (jump)     c = RD_JUMP;
      else if (retfie)   c = RD_RETFIE;
      else if (ret)      c = RD_RET;
      else if (rel)      c = RD_REL;
      else if (skip)     c = RD_SKIP;
      else if (irq_take) c = RD_IRQ;
      else               c = RD_NONE;
      return c;
   endfunction

endpackage

// File: rtl/pic_stack.sv
// Circular hardware return stack with saturating level and sticky
// overflow/underflow flags. Push and pop are never requested together.
module pic_stack
   import pic_pkg::*;
#(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             pop_data,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] ptr_dec;

   // Explicit wrap keeps non-power-of-two depths correct.
   assign ptr_inc  = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   assign ptr_dec  = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);
   assign pop_data = mem[ptr_dec];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (push) begin
         ptr <= ptr_inc;
         if (level == LVL_W'(DEPTH)) begin
            overflow <= 1'b1;
         end else begin
            level <= level + LVL_W'(1);
         end
      end else if (pop) begin
         ptr <= ptr_dec;
         if (level == '0) begin
            underflow <= 1'b1;
         end else begin
            level <= level - LVL_W'(1);
         end
      end
   end

endmodule

// File: rtl/pic_sequencer.sv
// Program sequencer: 2-stage overlapped fetch/execute with redirects, skip,
// return stack and interrupt entry.
module pic_sequencer
   import pic_pkg::*;
#(
   parameter int unsigned PC_W        = 11,
   parameter int unsigned INSTR_W     = 14,
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned RESET_VEC   = 0,
   parameter int unsigned INT_VEC     = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   output logic [PC_W-1:0]                    rom_addr,
   input  logic [INSTR_W-1:0]                 rom_data,
   output logic [INSTR_W-1:0]                 ir,
   output logic                               ir_valid,
   output logic [PC_W-1:0]                    pc,
   input  logic                               stall,
   input  logic                               jump_req,
   input  logic [PC_W-1:0]                    jump_target,
   input  logic                               call_req,
   input  logic                               ret_req,
   input  logic                               retfie_req,
   input  logic                               rel_req,
   input  logic [PC_W-1:0]                    rel_off,
   input  logic                               skip_req,
   input  logic                               ei_req,
   input  logic                               irq,
   output logic                               int_ack,
   output logic                               gie,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_level,
   output logic                               stk_overflow,
   output logic                               stk_underflow
);

   seq_state_t      state;
   redirect_t       cause;
   logic            live;
   logic            push;
   logic            pop;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pop_data;

   // Requests only count for a live instruction in a running, unstalled slot.
   assign live    = (state == S_RUN) && ir_valid && !stall;
   assign pc_next = pc + PC_W'(1);

   always_comb begin
      cause = RD_NONE;
      if (live) begin
         cause = pick_cause(call_req, jump_req, ret_req, retfie_req, rel_req, skip_req,
                            irq && gie);
      end
   end

   always_comb begin
      target = pc_next;
      case (cause)
         RD_JUMP, RD_CALL:  target = jump_target;
         RD_RET, RD_RETFIE: target = pop_data;
         RD_REL:            target = pc_next + rel_off;
         RD_IRQ:            target = PC_W'(INT_VEC);
         default:           target = pc_next;
      endcase
   end

   assign push = rst_n && ((cause == RD_CALL) || (cause == RD_IRQ));
   assign pop  = rst_n && ((cause == RD_RET) || (cause == RD_RETFIE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_FILL;
         rom_addr <= PC_W'(RESET_VEC);
         ir       <= INSTR_W'(NOP_INSTR);
         ir_valid <= 1'b0;
         pc       <= PC_W'(RESET_VEC);
         gie      <= 1'b0;
         int_ack  <= 1'b0;
      end else if (stall) begin
         int_ack <= 1'b0;
      end else begin
         int_ack <= 1'b0;
         // Every cycle latches the word at rom_addr; redirects just mark it squashed.
         ir <= rom_data;
         pc <= rom_addr;
         case (state)
            S_FILL, S_FLUSH: begin
               rom_addr <= rom_addr + PC_W'(1);
               ir_valid <= 1'b1;
               state    <= S_RUN;
            end
            S_RUN: begin
               if ((cause == RD_NONE) || (cause == RD_SKIP)) begin
                  rom_addr <= rom_addr + PC_W'(1);
                  ir_valid <= (cause == RD_NONE);
               end else begin
                  rom_addr <= target;
                  ir_valid <= 1'b0;
                  state    <= S_FLUSH;
               end
               if (cause == RD_IRQ) begin
                  gie     <= 1'b0;
                  int_ack <= 1'b1;
               end else if ((cause == RD_RETFIE) || (live && ei_req)) begin
                  gie <= 1'b1;
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

   pic_stack #(
      .WIDTH (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_next),
      .pop_data  (pop_data),
      .level     (stk_level),
      .overflow  (stk_overflow),
      .underflow (stk_underflow)
   );

endmodule

// File: tb/tb_pic_sequencer.sv
// Vector-table bench for pic_sequencer against a linear ROM (word = address).
module tb_pic_sequencer;
   import pic_pkg::*;

   localparam int unsigned PC_W    = 11;
   localparam int unsigned INSTR_W = 14;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned LVL_W   = $clog2(DEPTH + 1);

   typedef enum int {Q_NONE, Q_JUMP, Q_CALL, Q_RET, Q_RETFIE, Q_REL, Q_SKIP, Q_EI} req_e;

   typedef struct {
      bit   rst;
      bit   stl;
      req_e req;
      bit   irqv;
      int   arg;
      bit   valid;
      bit   chk;
      int   pc_e;
      int   addr;
      bit   gie_e;
      bit   ack;
      int   lvl;
      bit   ovf;
      bit   unf;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [PC_W-1:0]    rom_addr;
   logic [INSTR_W-1:0] rom_data;
   logic [INSTR_W-1:0] ir;
   logic               ir_valid;
   logic [PC_W-1:0]    pc;
   logic               stall, jump_req, call_req, ret_req, retfie_req, rel_req;
   logic               skip_req, ei_req, irq;
   logic [PC_W-1:0]    jump_target, rel_off;
   logic               int_ack, gie, stk_overflow, stk_underflow;
   logic [LVL_W-1:0]   stk_level;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   assign rom_data = INSTR_W'(rom_addr);

   always #5 clk = ~clk;

   pic_sequencer #(
      .PC_W        (PC_W),
      .INSTR_W     (INSTR_W),
      .STACK_DEPTH (DEPTH),
      .RESET_VEC   (0),
      .INT_VEC     (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .ir            (ir),
      .ir_valid      (ir_valid),
      .pc            (pc),
      .stall         (stall),
      .jump_req      (jump_req),
      .jump_target   (jump_target),
      .call_req      (call_req),
      .ret_req       (ret_req),
      .retfie_req    (retfie_req),
      .rel_req       (rel_req),
      .rel_off       (rel_off),
      .skip_req      (skip_req),
      .ei_req        (ei_req),
      .irq           (irq),
      .int_ack       (int_ack),
      .gie           (gie),
      .stk_level     (stk_level),
      .stk_overflow  (stk_overflow),
      .stk_underflow (stk_underflow)
   );

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s vec %0d: got 0x%0h, want 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input bit r, input bit s, input req_e q, input bit i, input int a,
                      input bit v, input bit c, input int p, input int ad, input bit g,
                      input bit k, input int l, input bit o, input bit u);
      vec_t t;
      t.rst = r;  t.stl = s;  t.req = q;  t.irqv = i;  t.arg = a;
      t.valid = v;  t.chk = c;  t.pc_e = p;  t.addr = ad;
      t.gie_e = g;  t.ack = k;  t.lvl = l;  t.ovf = o;  t.unf = u;
      vecs.push_back(t);
   endtask

   task automatic drive(input vec_t v);
      rst_n       = v.rst;
      stall       = v.stl;
      jump_req    = (v.req == Q_JUMP);
      call_req    = (v.req == Q_CALL);
      ret_req     = (v.req == Q_RET);
      retfie_req  = (v.req == Q_RETFIE);
      rel_req     = (v.req == Q_REL);
      skip_req    = (v.req == Q_SKIP);
      ei_req      = (v.req == Q_EI);
      irq         = v.irqv;
      jump_target = PC_W'(v.arg);
      rel_off     = PC_W'(v.arg);
   endtask

   task automatic compare(input int idx);
      vec_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_miss++;
         $display("FAIL scoreboard vec %0d: got empty queue, want an entry", idx);
         return;
      end
      e = exp_q.pop_front();
      check("ir_valid", idx, 32'(ir_valid), 32'(e.valid));
      if (e.chk) check("pc", idx, 32'(pc), 32'(e.pc_e));
      if (e.chk && e.valid) check("ir", idx, 32'(ir), 32'(e.pc_e));
      check("rom_addr", idx, 32'(rom_addr), 32'(e.addr));
      check("gie", idx, 32'(gie), 32'(e.gie_e));
      check("int_ack", idx, 32'(int_ack), 32'(e.ack));
      check("stk_level", idx, 32'(stk_level), 32'(e.lvl));
      check("stk_overflow", idx, 32'(stk_overflow), 32'(e.ovf));
      check("stk_underflow", idx, 32'(stk_underflow), 32'(e.unf));
   endtask

   initial begin
      int edges;
      vec_t z;
      z = '{rst: 0, stl: 0, req: Q_NONE, irqv: 0, arg: 0, valid: 0, chk: 0, pc_e: 0,
            addr: 0, gie_e: 0, ack: 0, lvl: 0, ovf: 0, unf: 0};
      drive(z);

      // Reset must dominate a request presented alongside it.
      jump_req    = 1'b1;
      jump_target = PC_W'('h55);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_vec++;
         check("rst_rom_addr", i, 32'(rom_addr), 32'h0);
         check("rst_ir", i, 32'(ir), 32'h0);
         check("rst_ir_valid", i, 32'(ir_valid), 32'h0);
         check("rst_int_ack", i, 32'(int_ack), 32'h0);
      end

      //   rst s  req       irq arg      vld chk pc      addr     gie ack lvl ovf unf
      add(0, 0, Q_NONE,   0, 'h000,   0, 1, 'h000, 'h000,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h000, 'h001,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h001, 'h002,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h002, 'h003,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h003, 'h004,   0, 0, 0, 0, 0);
      add(1, 0, Q_JUMP,   0, 'h020,   0, 0, 'h000, 'h020,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h020, 'h021,   0, 0, 0, 0, 0);
      add(1, 0, Q_JUMP,   0, 'h005,   0, 0, 'h000, 'h005,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h005, 'h006,   0, 0, 0, 0, 0);
      add(1, 0, Q_CALL,   0, 'h040,   0, 0, 'h000, 'h040,   0, 0, 1, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h040, 'h041,   0, 0, 1, 0, 0);
      add(1, 0, Q_RET,    0, 'h000,   0, 0, 'h000, 'h006,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h006, 'h007,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h007, 'h008,   0, 0, 0, 0, 0);
      add(1, 0, Q_SKIP,   0, 'h000,   0, 1, 'h008, 'h009,   0, 0, 0, 0, 0);
      // Jump offered in the squashed slot must be ignored.
      add(1, 0, Q_JUMP,   0, 'h030,   1, 1, 'h009, 'h00A,   0, 0, 0, 0, 0);
      add(1, 0, Q_JUMP,   0, 'h010,   0, 0, 'h000, 'h010,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h010, 'h011,   0, 0, 0, 0, 0);
      add(1, 0, Q_CALL,   0, 'h011,   0, 0, 'h000, 'h011,   0, 0, 1, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h011, 'h012,   0, 0, 1, 0, 0);
      add(1, 0, Q_CALL,   0, 'h012,   0, 0, 'h000, 'h012,   0, 0, 2, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h012, 'h013,   0, 0, 2, 0, 0);
      add(1, 0, Q_CALL,   0, 'h013,   0, 0, 'h000, 'h013,   0, 0, 3, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h013, 'h014,   0, 0, 3, 0, 0);
      add(1, 0, Q_CALL,   0, 'h014,   0, 0, 'h000, 'h014,   0, 0, 4, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h014, 'h015,   0, 0, 4, 0, 0);
      add(1, 0, Q_CALL,   0, 'h015,   0, 0, 'h000, 'h015,   0, 0, 4, 1, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h015, 'h016,   0, 0, 4, 1, 0);
      add(1, 0, Q_RET,    0, 'h000,   0, 0, 'h000, 'h015,   0, 0, 3, 1, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h015, 'h016,   0, 0, 3, 1, 0);
      add(1, 0, Q_RET,    0, 'h000,   0, 0, 'h000, 'h014,   0, 0, 2, 1, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h014, 'h015,   0, 0, 2, 1, 0);
      add(1, 0, Q_RET,    0, 'h000,   0, 0, 'h000, 'h013,   0, 0, 1, 1, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h013, 'h014,   0, 0, 1, 1, 0);
      add(1, 0, Q_RET,    0, 'h000,   0, 0, 'h000, 'h012,   0, 0, 0, 1, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h012, 'h013,   0, 0, 0, 1, 0);
      add(1, 0, Q_RET,    0, 'h000,   0, 0, 'h000, 'h015,   0, 0, 0, 1, 1);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h015, 'h016,   0, 0, 0, 1, 1);
      add(1, 0, Q_JUMP,   0, 'h7FF,   0, 0, 'h000, 'h7FF,   0, 0, 0, 1, 1);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h7FF, 'h000,   0, 0, 0, 1, 1);
      add(1, 0, Q_REL,    0, 'h001,   0, 0, 'h000, 'h001,   0, 0, 0, 1, 1);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h001, 'h002,   0, 0, 0, 1, 1);
      add(1, 0, Q_REL,    0, 'h7FE,   0, 0, 'h000, 'h000,   0, 0, 0, 1, 1);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h000, 'h001,   0, 0, 0, 1, 1);
      add(1, 0, Q_JUMP,   0, 'h011,   0, 0, 'h000, 'h011,   0, 0, 0, 1, 1);
      add(1, 0, Q_NONE,   1, 'h000,   1, 1, 'h011, 'h012,   0, 0, 0, 1, 1);
      add(1, 0, Q_EI,     1, 'h000,   1, 1, 'h012, 'h013,   1, 0, 0, 1, 1);
      add(1, 0, Q_NONE,   1, 'h000,   0, 0, 'h000, 'h004,   0, 1, 1, 1, 1);
      add(1, 1, Q_NONE,   1, 'h000,   0, 0, 'h000, 'h004,   0, 0, 1, 1, 1);
      add(1, 1, Q_JUMP,   1, 'h033,   0, 0, 'h000, 'h004,   0, 0, 1, 1, 1);
      add(1, 1, Q_NONE,   1, 'h000,   0, 0, 'h000, 'h004,   0, 0, 1, 1, 1);
      add(1, 0, Q_NONE,   1, 'h000,   1, 1, 'h004, 'h005,   0, 0, 1, 1, 1);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h005, 'h006,   0, 0, 1, 1, 1);
      add(1, 0, Q_RETFIE, 0, 'h000,   0, 0, 'h000, 'h013,   1, 0, 0, 1, 1);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h013, 'h014,   1, 0, 0, 1, 1);
      // Entry beats a same-cycle ei_req.
      add(1, 0, Q_EI,     1, 'h000,   0, 0, 'h000, 'h004,   0, 1, 1, 1, 1);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h004, 'h005,   0, 0, 1, 1, 1);
      add(0, 1, Q_NONE,   0, 'h000,   0, 1, 'h000, 'h000,   0, 0, 0, 0, 0);
      add(1, 0, Q_NONE,   0, 'h000,   1, 1, 'h000, 'h001,   0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i]);
         exp_q.push_back(vecs[i]);
         @(posedge clk); #1;
         compare(i);
      end

      // Bounded wait: first valid slot must follow the single fill cycle.
      drive(z);
      @(posedge clk); #1;
      rst_n = 1'b1;
      edges = 0;
      while (!ir_valid && edges < 8) begin
         @(posedge clk); #1;
         edges++;
      end
      n_vec++;
      check("first_valid_latency", 0, 32'(edges), 32'd1);
      check("first_valid_pc", 0, 32'(pc), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
